// File: rtl/bist_signature_checker_if.sv
// Table-write, request and response signals of the BIST golden-signature checker.
// The master side is the MISR/reporting logic; the slave side is the checker.
interface bist_signature_checker_if #(
  parameter int SIG_W = 36,
  parameter int TAG_W = 4,
  parameter int IDX_W = 6
);
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [SIG_W-1:0] wr_sig;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_clr;
  logic             wr_err;
  logic             req_valid;
  logic             req_ready;
  logic [SIG_W-1:0] req_sig;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_sig_hit;
  logic             resp_found;
  logic [IDX_W-1:0] resp_idx;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output wr_en, wr_addr, wr_sig, wr_tag, wr_clr,
    output req_valid, req_sig, req_tag, resp_ready,
    input  wr_err, req_ready, resp_valid, resp_sig_hit, resp_found, resp_idx, resp_tag
  );

  modport slave (
    input  wr_en, wr_addr, wr_sig, wr_tag, wr_clr,
    input  req_valid, req_sig, req_tag, resp_ready,
    output wr_err, req_ready, resp_valid, resp_sig_hit, resp_found, resp_idx, resp_tag
  );
endinterface

// File: rtl/bist_signature_checker.sv
// Golden-signature table with a sequential, lowest-index-first search per request.
// Define BIST_STICKY_FAIL_EN to add the fail_sticky / fail_cnt result summary outputs.
//
// state  | meaning
// IDLE   | ready for a request; table writes and clears accepted
// SEARCH | comparing entry[idx] against the latched signature, one per cycle
// RESP   | result held on the response handshake until accepted
module bist_signature_checker #(
  parameter int SIG_W = 36,
  parameter int TAG_W = 4,
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input logic                       clk,
  input logic                       rst,
  bist_signature_checker_if.slave   bus
`ifdef BIST_STICKY_FAIL_EN
  ,
  output logic                      fail_sticky,
  output logic [7:0]                fail_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [SIG_W-1:0] sig_q;
  logic [TAG_W-1:0] tag_q;

  logic [DEPTH-1:0] vld;
  logic [SIG_W-1:0] sig_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic entry_hit;
  logic last_idx;
  logic tbl_wr;

  assign entry_hit = vld[idx] && (sig_mem[idx] == sig_q);
  assign last_idx  = (idx == IDX_W'(DEPTH - 1));
  // A clear in the same cycle as a write wins and silently drops the write.
  assign tbl_wr    = (state == IDLE) && bus.wr_en && !bus.wr_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (state == IDLE) begin
      if (bus.wr_clr)
        vld <= '0;
      else if (bus.wr_en)
        vld[bus.wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      sig_mem[bus.wr_addr] <= bus.wr_sig;
      tag_mem[bus.wr_addr] <= bus.wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      sig_q            <= '0;
      tag_q            <= '0;
      bus.req_ready    <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.resp_sig_hit <= 1'b0;
      bus.resp_found   <= 1'b0;
      bus.resp_idx     <= '0;
      bus.resp_tag     <= '0;
      bus.wr_err       <= 1'b0;
    end else begin
      bus.wr_err <= (state != IDLE) && (bus.wr_en || bus.wr_clr);
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            sig_q         <= bus.req_sig;
            tag_q         <= bus.req_tag;
            idx           <= '0;
            bus.req_ready <= 1'b0;
            state         <= SEARCH;
          end
        end
        SEARCH: begin
          if (entry_hit) begin
            bus.resp_sig_hit <= 1'b1;
            bus.resp_found   <= (tag_mem[idx] == tag_q);
            bus.resp_idx     <= idx;
            bus.resp_tag     <= tag_mem[idx];
            bus.resp_valid   <= 1'b1;
            state            <= RESP;
          end else if (last_idx) begin
            bus.resp_sig_hit <= 1'b0;
            bus.resp_found   <= 1'b0;
            bus.resp_idx     <= '0;
            bus.resp_tag     <= '0;
            bus.resp_valid   <= 1'b1;
            state            <= RESP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

`ifdef BIST_STICKY_FAIL_EN
  // Any accepted response that is not a full sig+tag match counts as a failure.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_sticky <= 1'b0;
      fail_cnt    <= '0;
    end else if (state == RESP && bus.resp_ready && !bus.resp_found) begin
      fail_sticky <= 1'b1;
      if (fail_cnt != 8'hFF)
        fail_cnt <= fail_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bist_signature_checker.sv
// Directed test of bist_signature_checker; also covers fail_sticky/fail_cnt when
// BIST_STICKY_FAIL_EN is defined.
module tb_bist_signature_checker;
  localparam int SIG_W = 36;
  localparam int TAG_W = 4;
  localparam int DEPTH = 64;
  localparam int IDX_W = 6;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_fail;

  bist_signature_checker_if #(.SIG_W(SIG_W), .TAG_W(TAG_W), .IDX_W(IDX_W)) bus ();

`ifdef BIST_STICKY_FAIL_EN
  logic       fail_sticky;
  logic [7:0] fail_cnt;
`endif

  bist_signature_checker #(.SIG_W(SIG_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef BIST_STICKY_FAIL_EN
    ,
    .fail_sticky(fail_sticky),
    .fail_cnt(fail_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [IDX_W-1:0] a, input logic [SIG_W-1:0] s,
                             input logic [TAG_W-1:0] t);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_sig = s; bus.wr_tag = t;
    step();
    bus.wr_en = 1'b0;
  endtask

  // Presents the request across the accept edge E0; any write set up by the caller
  // is held over the same edge and dropped afterwards.
  task automatic start_req(input logic [SIG_W-1:0] s, input logic [TAG_W-1:0] t);
    bus.req_valid = 1'b1; bus.req_sig = s; bus.req_tag = t;
    step();
    bus.req_valid = 1'b0; bus.wr_en = 1'b0; bus.wr_clr = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int already, input int exp_lat,
                           input logic exp_hit, input logic exp_found,
                           input logic [IDX_W-1:0] exp_idx, input logic [TAG_W-1:0] exp_tag);
    int lat;
    lat = already;
    while (bus.resp_valid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    chk({name, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({name, ".req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({name, ".sig_hit"}, 64'(bus.resp_sig_hit), 64'(exp_hit));
    chk({name, ".found"}, 64'(bus.resp_found), 64'(exp_found));
    chk({name, ".idx"}, 64'(bus.resp_idx), 64'(exp_idx));
    chk({name, ".tag"}, 64'(bus.resp_tag), 64'(exp_tag));
  endtask

  task automatic handshake(input string name, input logic exp_found);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    if (!exp_found) exp_fail++;
    chk({name, ".resp_valid_drop"}, 64'(bus.resp_valid), 64'd0);
    chk({name, ".req_ready_back"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    int seen;
    checks = 0; failures = 0; exp_fail = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_sig = '0; bus.wr_tag = '0; bus.wr_clr = 1'b0;
    bus.req_valid = 1'b0; bus.req_sig = '0; bus.req_tag = '0; bus.resp_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst.req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst.outputs", {bus.resp_sig_hit, bus.resp_found, bus.resp_idx, bus.resp_tag}, 64'd0);
    chk("rst.wr_err", 64'(bus.wr_err), 64'd0);

    // Reset held two cycles in the middle of a search aborts it.
    start_req(36'h7A778A140, 4'h8);
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("abort.req_ready", 64'(bus.req_ready), 64'd1);
    chk("abort.resp_valid", 64'(bus.resp_valid), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("abort.outputs", {bus.resp_sig_hit, bus.resp_found, bus.resp_idx, bus.resp_tag}, 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.resp_valid === 1'b1) seen++;
      step();
    end
    chk("abort.no_resp", 64'(seen), 64'd0);
    start_req(36'h7A778A140, 4'h8);
    wait_resp("abort_miss", 0, DEPTH, 1'b0, 1'b0, 6'd0, 4'h0);
    handshake("abort_miss", 1'b0);

    write_entry(6'd0, 36'h7A778A140, 4'h8);
    start_req(36'h7A778A140, 4'h8);
    wait_resp("hit0", 0, 1, 1'b1, 1'b1, 6'd0, 4'h8);
    handshake("hit0", 1'b1);

    write_entry(6'd5, 36'hAC790E5ED, 4'h7);
    start_req(36'hAC790E5ED, 4'h3);
    wait_resp("hit5_tagmis", 0, 6, 1'b1, 1'b0, 6'd5, 4'h7);
    handshake("hit5_tagmis", 1'b0);

    write_entry(6'd9, 36'h0DEADBEEF, 4'hC);
    write_entry(6'd3, 36'h0DEADBEEF, 4'h2);
    start_req(36'h0DEADBEEF, 4'hC);
    wait_resp("lowest", 0, 4, 1'b1, 1'b0, 6'd3, 4'h2);
    handshake("lowest", 1'b0);

    // Miss with the consumer stalling: everything must hold.
    start_req(36'h123456789, 4'h1);
    wait_resp("miss", 0, DEPTH, 1'b0, 1'b0, 6'd0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold.resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("hold.req_ready", 64'(bus.req_ready), 64'd0);
      chk("hold.outputs", {bus.resp_sig_hit, bus.resp_found, bus.resp_idx, bus.resp_tag}, 64'd0);
    end
    handshake("miss", 1'b0);

    // Write during SEARCH is dropped with a one-cycle error pulse.
    start_req(36'hAC790E5ED, 4'h7);
    bus.wr_en = 1'b1; bus.wr_addr = 6'd5; bus.wr_sig = 36'h111111111; bus.wr_tag = 4'h1;
    step();
    bus.wr_en = 1'b0;
    chk("wr_busy.err", 64'(bus.wr_err), 64'd1);
    step();
    chk("wr_busy.err_drop", 64'(bus.wr_err), 64'd0);
    wait_resp("wr_busy", 2, 6, 1'b1, 1'b1, 6'd5, 4'h7);
    handshake("wr_busy", 1'b1);
    start_req(36'h111111111, 4'h1);
    wait_resp("wr_busy_readback", 0, DEPTH, 1'b0, 1'b0, 6'd0, 4'h0);
    handshake("wr_busy_readback", 1'b0);

    // Clear during RESP is dropped as well.
    start_req(36'h7A778A140, 4'h8);
    wait_resp("clr_busy", 0, 1, 1'b1, 1'b1, 6'd0, 4'h8);
    bus.wr_clr = 1'b1;
    step();
    bus.wr_clr = 1'b0;
    chk("clr_busy.err", 64'(bus.wr_err), 64'd1);
    chk("clr_busy.resp_held", 64'(bus.resp_valid), 64'd1);
    step();
    chk("clr_busy.err_drop", 64'(bus.wr_err), 64'd0);
    handshake("clr_busy", 1'b1);
    start_req(36'h7A778A140, 4'h8);
    wait_resp("clr_busy_readback", 0, 1, 1'b1, 1'b1, 6'd0, 4'h8);
    handshake("clr_busy_readback", 1'b1);

    // Write and request in the same IDLE cycle: the search sees the new entry.
    bus.wr_en = 1'b1; bus.wr_addr = 6'd2; bus.wr_sig = 36'hF0F0F0F0F; bus.wr_tag = 4'h6;
    start_req(36'hF0F0F0F0F, 4'h6);
    chk("wr_same.err", 64'(bus.wr_err), 64'd0);
    wait_resp("wr_same", 0, 3, 1'b1, 1'b1, 6'd2, 4'h6);
    handshake("wr_same", 1'b1);

    start_req(36'h0, 4'h0);
    wait_resp("zero_miss", 0, DEPTH, 1'b0, 1'b0, 6'd0, 4'h0);
    handshake("zero_miss", 1'b0);
    write_entry(6'd7, 36'h0, 4'h4);
    start_req(36'h0, 4'h4);
    wait_resp("zero_hit", 0, 8, 1'b1, 1'b1, 6'd7, 4'h4);
    handshake("zero_hit", 1'b1);

    // Clear beats a simultaneous write, without an error.
    bus.wr_clr = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 6'd1;
    bus.wr_sig = 36'h7A778A140; bus.wr_tag = 4'h8;
    step();
    bus.wr_clr = 1'b0; bus.wr_en = 1'b0;
    chk("clr_wins.err", 64'(bus.wr_err), 64'd0);
    start_req(36'h7A778A140, 4'h8);
    wait_resp("clr_wins", 0, DEPTH, 1'b0, 1'b0, 6'd0, 4'h0);
    handshake("clr_wins", 1'b0);

`ifdef BIST_STICKY_FAIL_EN
    chk("fail_cnt", 64'(fail_cnt), 64'(exp_fail));
    chk("fail_sticky", 64'(fail_sticky), 64'(exp_fail != 0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bist_signature_checker.md
Name: bist_signature_checker

Overview:
- Parametrised golden-signature checker for logic BIST.
- Holds a writable table of DEPTH entries; each entry is {SIG_W-bit signature, TAG_W-bit tag, valid bit}.
- Accepts a compacted MISR signature plus expected tag over a valid/ready handshake and searches the table sequentially, one entry per cycle.
- Returns hit/match status, matched index and stored tag over a held response handshake.
- Sits between the MISR/compactor and the BIST result reporting logic.

Parameters:
- SIG_W, 36, signature width in bits.
- TAG_W, 4, tag width in bits (pattern-set / test-phase id).
- DEPTH, 64, number of table entries; power of 2, minimum 2.
- IDX_W, 6, index width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  table write strobe.
- wr_addr  input  IDX_W  table entry to write.
- wr_sig  input  SIG_W  signature to store.
- wr_tag  input  TAG_W  tag to store.
- wr_clr  input  1  clear all valid bits.
- wr_err  output  1  one-cycle pulse: write or clear dropped because the block was busy.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_sig  input  SIG_W  signature under test.
- req_tag  input  TAG_W  expected tag.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_sig_hit  output  1  a valid entry's signature equals req_sig.
- resp_found  output  1  sig hit and stored tag == req_tag.
- resp_idx  output  IDX_W  index of matching entry; 0 on miss.
- resp_tag  output  TAG_W  stored tag of matching entry; 0 on miss.

Behaviour:
- Reset values:
  - FSM = IDLE; all valid bits cleared (signature and tag contents don't-care).
  - req_ready=1, resp_valid=0, resp_sig_hit=0, resp_found=0, resp_idx=0, resp_tag=0, wr_err=0.
- Reset mid-search or mid-response aborts the operation; no response is produced.
- FSM states are IDLE, SEARCH and RESP.
- IDLE:
  - req_ready=1.
  - req_valid && req_ready latches req_sig/req_tag, sets idx=0 and moves to SEARCH.
- SEARCH:
  - req_ready=0.
  - Each cycle compares entry[idx]; a hit requires valid && sig equality.
  - On the first hit (lowest index wins), capture sig_hit=1, found=(tag==latched tag), idx and stored tag, then go to RESP.
  - On a miss at idx=DEPTH-1, capture all-zero results and go to RESP.
  - Otherwise increment idx.
- RESP:
  - resp_valid=1 and all result outputs held stable until resp_valid && resp_ready.
  - After that handshake: IDLE, resp_valid=0.
- Latency:
  - Accept edge is E0.
  - Hit at index k: resp_valid is high after edge E(k+1).
  - Miss: resp_valid is high after edge E(DEPTH).
- Back-to-back requests:
  - req_ready is 0 in RESP, so a new request is accepted no earlier than the cycle after the response handshake.
  - Minimum one IDLE cycle between jobs.
- Table writes:
  - Accepted only in IDLE.
  - wr_en writes sig/tag and sets the valid bit at wr_addr.
  - wr_clr clears all valid bits; when wr_clr and wr_en occur in the same cycle, wr_clr wins and the write is dropped without an error.
  - When wr_en or wr_clr is asserted outside IDLE, the table is unchanged and wr_err pulses for 1 cycle.
  - A write and a request accepted in the same IDLE cycle: the write is visible to that search.
- A signature of all zeros is an ordinary value; it matches only a valid entry holding zero.
- Wrap-around: idx never wraps during a search; the search terminates at DEPTH-1.

Optional Feature:
- Macro: BIST_STICKY_FAIL_EN.
- Enabled:
  - Adds output fail_sticky (1 bit), set on any response handshake with resp_found=0.
  - Adds output fail_cnt (8 bits), incremented on such handshakes and saturating at 255.
  - Both are cleared only by rst.
- Disabled: neither port exists; no extra logic.

Test Plan:
- Reset defaults: assert rst 2 cycles mid-SEARCH -> next cycle FSM IDLE, req_ready=1, resp_valid=0, all result outputs 0, no response produced; then a request for any signature -> miss.
- Write entry 0 = (36'h7A778A140, 4'h8); request (36'h7A778A140, 4'h8) -> resp_valid after E1, sig_hit=1, found=1, idx=0, tag=8.
- Write entry 5 = (36'hAC790E5ED, 4'h7); request (36'hAC790E5ED, 4'h3) -> after E6, sig_hit=1, found=0, idx=5, tag=7.
- Same signature in entries 3 and 9 with different tags -> idx=3 reported (lowest wins).
- Miss: request 36'h123456789 on the populated table -> after E64, sig_hit=0, found=0, idx=0; hold resp_ready=0 for 5 cycles -> outputs stable, req_ready=0.
- wr_en during SEARCH -> wr_err pulses 1 cycle, entry unchanged on readback search; with BIST_STICKY_FAIL_EN, three miss handshakes -> fail_cnt=3, fail_sticky=1.
